// File: rtl/out_channel.sv
// out_channel: circular output FIFO with ACTIVE/DRAIN/DONE end-of-program tracking.
// Latency: push to readValid is 1 cycle (show-ahead head word, no write bypass).
// Backpressure: readReady stalls pops; a write into a full buffer with no pop is dropped and sets sticky overflow.
// Optional feature: define OUT_CHANNEL_CHECKSUM_EN to enable the running checksum of popped words.
module out_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          outWrite,
  input  logic [MemoryElementWidth-1:0] outData,
  input  logic                          finished,
  output logic                          outFull,
  output logic                          readValid,
  input  logic                          readReady,
  output logic [MemoryElementWidth-1:0] readData,
  output logic [$clog2(NOut+1)-1:0]     count,
  output logic                          overflow,
  output logic                          drained,
  output logic [MemoryElementWidth-1:0] checksum
);

  localparam int W  = MemoryElementWidth;
  localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
  localparam int CW = $clog2(NOut + 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic [W-1:0]  mem [NOut];

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          drained_q, drained_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          not_empty;

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CW'(NOut));
  assign pop       = not_empty && readReady;
  assign push      = outWrite && (state_q != DONE) && (!full || pop);

  assign outFull   = full;
  assign readValid = not_empty;
  // Storage is not cleared on reset, so mask the head word while empty.
  assign readData  = not_empty ? mem[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drained   = drained_q;

  // Next-state for pointers, occupancy, sticky flags and the end-of-program FSM.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drained_d  = drained_q;
    state_d    = state_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(NOut - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(NOut - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    // Words refused while DONE are intentional discards, not overflow.
    if (outWrite && (state_q != DONE) && full && !pop) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      ACTIVE: begin
        if (finished) begin
          state_d = (count_q == '0 && !outWrite) ? DONE : DRAIN;
        end
      end
      // finished is no longer looked at; DONE is reached the edge the buffer empties.
      DRAIN: begin
        if (count_d == '0 && !push) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = ACTIVE;
    endcase

    if (state_d == DONE) begin
      drained_d = 1'b1;
    end
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ACTIVE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drained_q  <= drained_d;
    end
  end

  // Word storage; contents survive reset, occupancy tracking makes them invisible.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= outData;
    end
  end

`ifdef OUT_CHANNEL_CHECKSUM_EN
  logic [W-1:0] checksum_q, checksum_d;

  // Accumulate each popped word, wrapping at the word width.
  always_comb begin
    checksum_d = checksum_q;
    if (pop) begin
      checksum_d = checksum_q + readData;
    end
  end

  // Checksum register, visible the cycle after the pop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_out_channel.sv
// Directed bench for out_channel (NOut=16, 12-bit words); self-checking with immediate assertions.
// Build with OUT_CHANNEL_CHECKSUM_EN defined to also check the checksum value.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_out_channel;

  localparam int W  = 12;
  localparam int N  = 16;
  localparam int CW = $clog2(N + 1);

  logic          clock;
  logic          reset;
  logic          outWrite;
  logic [W-1:0]  outData;
  logic          finished;
  logic          outFull;
  logic          readValid;
  logic          readReady;
  logic [W-1:0]  readData;
  logic [CW-1:0] count;
  logic          overflow;
  logic          drained;
  logic [W-1:0]  checksum;

  int tests_run = 0;
  int tests_failed = 0;

  out_channel #(.MemoryElementWidth(W), .NOut(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .outWrite  (outWrite),
    .outData   (outData),
    .finished  (finished),
    .outFull   (outFull),
    .readValid (readValid),
    .readReady (readReady),
    .readData  (readData),
    .count     (count),
    .overflow  (overflow),
    .drained   (drained),
    .checksum  (checksum)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    outWrite  = 1'b0;
    readReady = 1'b0;
    finished  = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] v);
    outWrite = 1'b1;
    outData  = v;
    step();
    outWrite = 1'b0;
  endtask

  logic [W-1:0] seq1 [5];
  logic [W-1:0] seq4 [4];
  logic [31:0]  exp_sum;

  initial begin
    seq1 = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
    seq4 = '{12'd5, 12'd6, 12'd7, 12'd8};
    reset = 1'b0; outWrite = 1'b0; outData = '0; finished = 1'b0; readReady = 1'b0;

    // Reset state
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(readValid), 0);
    chk("rst_full", 32'(outFull), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drained", 32'(drained), 0);
    chk("rst_rdata", 32'(readData), 0);
    chk("rst_checksum", 32'(checksum), 0);
    reset = 1'b1;
    step();

    // Push 1,2,1,1,2 without popping, then drain in order
    outWrite = 1'b1; outData = seq1[0];
    #1;
    chk("no_comb_valid", 32'(readValid), 0);
    step();
    chk("push_latency_valid", 32'(readValid), 1);
    chk("push_latency_rdata", 32'(readData), 1);
    for (int i = 1; i < 5; i++) begin
      outData = seq1[i];
      step();
    end
    outWrite = 1'b0;
    chk("seq1_count5", 32'(count), 5);
    readReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("seq1_order", 32'(readData), 32'(seq1[i]));
      chk("seq1_count", 32'(count), 32'(5 - i));
      step();
    end
    readReady = 1'b0;
    chk("seq1_empty_count", 32'(count), 0);
    chk("seq1_empty_valid", 32'(readValid), 0);
    chk("seq1_empty_rdata", 32'(readData), 0);
`ifdef OUT_CHANNEL_CHECKSUM_EN
    exp_sum = 32'd7;
`else
    exp_sum = 32'd0;
`endif
    chk("seq1_checksum", 32'(checksum), exp_sum);

    // Overfill: 16 accepted, 17th dropped
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("fill_not_full", 32'(outFull), 0);
      push_word(12'(100 + i));
    end
    chk("fill_full", 32'(outFull), 1);
    chk("fill_no_ovf", 32'(overflow), 0);
    push_word(12'd999);
    chk("drop_overflow", 32'(overflow), 1);
    chk("drop_count", 32'(count), 16);
    readReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drop_order", 32'(readData), 32'(100 + i));
      step();
    end
    readReady = 1'b0;
    chk("drop_empty", 32'(count), 0);
    chk("drop_ovf_sticky", 32'(overflow), 1);

    // Push and pop in the same cycle while full
    do_reset();
    chk("reset_clears_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) push_word(12'(200 + i));
    outWrite = 1'b1; outData = 12'd300; readReady = 1'b1;
    chk("pp_head", 32'(readData), 200);
    step();
    outWrite = 1'b0;
    chk("pp_count", 32'(count), 16);
    chk("pp_full", 32'(outFull), 1);
    chk("pp_no_ovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      chk("pp_order", 32'(readData), 32'(200 + i));
      step();
    end
    chk("pp_new_word", 32'(readData), 300);
    chk("pp_new_count", 32'(count), 1);
    step();
    readReady = 1'b0;
    chk("pp_empty", 32'(count), 0);

    // finished with 3 buffered, push in DRAIN, drain to DONE
    do_reset();
    for (int i = 0; i < 3; i++) push_word(seq4[i]);
    finished = 1'b1;
    step();
    finished = 1'b0;
    chk("drain_not_done", 32'(drained), 0);
    push_word(seq4[3]);
    chk("drain_push_ok", 32'(count), 4);
    readReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(readData), 32'(seq4[i]));
      chk("drain_pending", 32'(drained), 0);
      step();
    end
    readReady = 1'b0;
    chk("drained_set", 32'(drained), 1);
    chk("drained_count", 32'(count), 0);
    push_word(12'd55);
    chk("done_ignore_count", 32'(count), 0);
    chk("done_ignore_valid", 32'(readValid), 0);
    chk("done_no_ovf", 32'(overflow), 0);
    chk("done_sticky", 32'(drained), 1);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) push_word(12'(40 + i));
    chk("ar_count4", 32'(count), 4);
    #2 reset = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_valid", 32'(readValid), 0);
    chk("ar_rdata", 32'(readData), 0);
    chk("ar_full", 32'(outFull), 0);
    chk("ar_drained", 32'(drained), 0);
    reset = 1'b1;
    step();
    push_word(12'd9);
    chk("ar_next_valid", 32'(readValid), 1);
    chk("ar_next_rdata", 32'(readData), 9);
    chk("ar_next_count", 32'(count), 1);
    readReady = 1'b1;
    step();
    chk("ar_next_popped", 32'(count), 0);

    // Advance pointers, then stream 24 words across two wraps
    for (int i = 0; i < 8; i++) begin
      outWrite = 1'b1; outData = 12'(i);
      step();
    end
    outWrite = 1'b0;
    step();
    chk("wrap_pre_empty", 32'(count), 0);
    for (int i = 0; i < 24; i++) begin
      outWrite = 1'b1; outData = 12'(500 + i);
      if (i > 0) chk("wrap_order", 32'(readData), 32'(500 + i - 1));
      step();
      chk("wrap_count", 32'(count), 1);
    end
    outWrite = 1'b0;
    chk("wrap_last", 32'(readData), 523);
    step();
    readReady = 1'b0;
    chk("wrap_empty", 32'(count), 0);
    chk("wrap_no_ovf", 32'(overflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
